// File: rtl/serial_subtractor_controller.sv
// Bit-serial WIDTH-bit subtractor: computes a - b - bin LSB first, one bit per
// clock, through a single full-subtractor cell with a registered borrow chain.
// Optional feature macro: SERIAL_SUB_OVERFLOW_EN adds the signed-overflow
// output ovf, registered at completion alongside result.

// One-bit full subtractor built from gates: d = a - b - bin, bout = borrow out.
module full_subtractor_structure (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic axb;

  assign axb  = a ^ b;
  assign d    = axb ^ bin;
  assign bout = (~a & b) | (~axb & bin);

endmodule

module serial_subtractor_controller #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             bout
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] work;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             cell_d;
  logic             cell_bout;

  // The single shared cell operates on the current LSBs and the chained borrow.
  full_subtractor_structure u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (borrow),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // Sequencer: accept in IDLE, shift one bit per RUN cycle, pulse done from FIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      work   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      bout   <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            borrow <= bin;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          work   <= {cell_d, work[WIDTH-1:1]};
          borrow <= cell_bout;
          // Counter saturates at WIDTH rather than wrapping.
          if (cnt != CW'(WIDTH)) begin
            cnt <= cnt + CW'(1);
          end
          if (cnt == CW'(WIDTH - 1)) begin
            result <= {cell_d, work[WIDTH-1:1]};
            bout   <= cell_bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
            // Borrow into the MSB differs from borrow out of it on signed overflow.
            ovf    <= borrow ^ cell_bout;
`endif
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= FIN;
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
